ysyx_25030081_sram: RTL and testbench

Memory responder on the CPU's fetch/load-store side. It accepts AXI4-Lite-style read and write requests from the core, waits a fixed number of cycles, then returns read data or a write response. It holds an internal word-addressed array, so the core can move from a combinational instruction input to a handshaked bus without any other change.

---
 rtl/ysyx_25030081_sram.sv | 187 ++++++++++++++++++
 tb/tb_ysyx_25030081_sram.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_25030081_sram.sv
// Word-addressed SRAM responder on an AXI4-Lite-style read/write bus, one transaction outstanding.
// Latency: LATENCY cycles from request handshake to rvalid/bvalid; one idle cycle after each response.
// Backpressure: responses are held stable until rready/bready; all ready outputs are low outside IDLE.
module ysyx_25030081_sram #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE       = 'h8000_0000,
  parameter int                    LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] araddr,
  input  logic                  arvalid,
  output logic                  arready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [1:0]            rresp,
  output logic                  rvalid,
  input  logic                  rready,
  input  logic [ADDR_WIDTH-1:0] awaddr,
  input  logic                  awvalid,
  output logic                  awready,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [3:0]            wstrb,
  input  logic                  wvalid,
  output logic                  wready,
  output logic [1:0]            bresp,
  output logic                  bvalid,
  input  logic                  bready
);

  localparam int                    DEPTH    = 1 << DEPTH_LOG2;
  localparam int                    CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CW-1:0]         CNT_INIT = CW'(LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(4) << DEPTH_LOG2;
  localparam logic [1:0]            OKAY     = 2'b00;
  localparam logic [1:0]            SLVERR   = 2'b10;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic [1:0]              bresp_q, bresp_d;

  logic [DATA_WIDTH-1:0]   mem [0:DEPTH-1];

  // The address/data actually being served: live inputs only matter when
  // LATENCY == 1 and the access completes straight out of IDLE.
  logic [ADDR_WIDTH-1:0]   acc_addr;
  logic [DATA_WIDTH-1:0]   acc_wdata;
  logic [3:0]              acc_strb;
  logic [ADDR_WIDTH-1:0]   offset;
  logic                    in_range;
  logic [DEPTH_LOG2-1:0]   idx;
  logic                    load_rd;
  logic                    commit;
  logic                    mem_we;

  // Address decode shared by the read capture and the write commit.
  always_comb begin
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_strb  = wstrb_q;
    if (state_q == IDLE) begin
      acc_addr  = arvalid ? araddr : awaddr;
      acc_wdata = wdata;
      acc_strb  = wstrb;
    end
    offset   = acc_addr - BASE;
    in_range = (acc_addr >= BASE) && (offset < SPAN);
    idx      = DEPTH_LOG2'(offset >> 2);
  end

  // Next-state, request acceptance and response capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    bresp_d = bresp_q;
    arready = 1'b0;
    awready = 1'b0;
    wready  = 1'b0;
    load_rd = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        arready = rst;
        awready = rst && !arvalid && awvalid && wvalid;
        wready  = awready;
        if (arvalid) begin
          addr_d = araddr;
          cnt_d  = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = RD_RESP;
            load_rd = 1'b1;
          end else begin
            state_d = RD_WAIT;
          end
        end else if (awvalid && wvalid) begin
          addr_d  = awaddr;
          wdata_d = wdata;
          wstrb_d = wstrb;
          cnt_d   = CNT_INIT;
          if (LATENCY == 1) begin
            state_d = WR_RESP;
            commit  = 1'b1;
          end else begin
            state_d = WR_WAIT;
          end
        end
      end
      RD_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = RD_RESP;
          load_rd = 1'b1;
        end
      end
      WR_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q <= CW'(1)) begin
          state_d = WR_RESP;
          commit  = 1'b1;
        end
      end
      RD_RESP: if (rready) state_d = IDLE;
      WR_RESP: if (bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (load_rd) begin
      rdata_d = in_range ? mem[idx] : '0;
      rresp_d = in_range ? OKAY : SLVERR;
    end
    if (commit) begin
      bresp_d = in_range ? OKAY : SLVERR;
    end
    mem_we = commit && in_range;
  end

  // Control and response registers; reset aborts any transaction in flight.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
      rresp_q <= '0;
      bresp_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      bresp_q <= bresp_d;
    end
  end

  // Byte-masked array write on the edge entering WR_RESP; contents survive reset.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (acc_strb[b]) mem[idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  assign rvalid = (state_q == RD_RESP);
  assign bvalid = (state_q == WR_RESP);
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign bresp  = bresp_q;

endmodule

// File: tb/tb_ysyx_25030081_sram.sv
// Randomised scoreboard bench for ysyx_25030081_sram with a flat memory model.
// Latency: checks response arrival exactly LATENCY cycles after each request handshake.
// Backpressure: rready/bready toggle randomly, with a forced 5-cycle hold on one read.
module tb_ysyx_25030081_sram;
  localparam int          LAT  = 2;
  localparam logic [31:0] BASE = 32'h8000_0000;

  logic        clk, rst;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic        arvalid, arready, rvalid, rready;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;
  logic [1:0]  rresp, bresp;

  ysyx_25030081_sram #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .DEPTH_LOG2(10),
                       .BASE(BASE), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit          is_rd;
    logic [31:0] data;
    logic [1:0]  resp;
    int          hs;
  } exp_t;

  exp_t        q[$];
  exp_t        mon_e;
  logic [31:0] ref_mem [0:1023];
  bit          hold_r = 0;
  bit          prev_vld = 0;
  int          last_r_hs = -100;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting (cycle %0d)", nm, cyc);
  endtask

  function automatic bit oor(input logic [31:0] a);
    return (a < BASE) || ((a - BASE) >= 32'd4096);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic push_read(input logic [31:0] a);
    exp_t e;
    e.is_rd = 1;
    e.data  = oor(a) ? 32'h0 : ref_mem[widx(a)];
    e.resp  = oor(a) ? 2'b10 : 2'b00;
    e.hs    = cyc;
    q.push_back(e);
  endtask

  task automatic push_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    exp_t e;
    e.is_rd = 0;
    e.data  = 32'h0;
    e.resp  = oor(a) ? 2'b10 : 2'b00;
    e.hs    = cyc;
    q.push_back(e);
    if (!oor(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[widx(a)][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic do_read(input logic [31:0] a);
    int n = 0;
    @(posedge clk); #1;
    arvalid = 1; araddr = a;
    @(negedge clk);
    while (!arready && n < 100) begin @(negedge clk); n++; end
    if (!arready) timeout("ar_wait");
    else push_read(a);
    @(posedge clk); #1;
    arvalid = 0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    @(posedge clk); #1;
    awvalid = 1; wvalid = 1; awaddr = a; wdata = d; wstrb = s;
    @(negedge clk);
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (!awready) timeout("aw_wait");
    else begin
      check("wready_with_awready", wready, 1);
      push_write(a, d, s);
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (q.size() != 0 && n < 200) begin @(negedge clk); n++; end
    if (q.size() != 0) timeout("drain");
  endtask

  function automatic logic [31:0] pick_addr();
    int r;
    logic [31:0] lo;
    r  = $urandom_range(9);
    lo = 32'($urandom_range(3));
    if (r <= 5)      return BASE + 32'(4 * $urandom_range(15)) + lo;
    else if (r <= 7) return BASE + 32'(4 * (1020 + $urandom_range(3))) + lo;
    else if (r == 8) return BASE - 32'(4 * (1 + $urandom_range(3))) + lo;
    else             return BASE + 32'd4096 + 32'(4 * $urandom_range(7)) + lo;
  endfunction

  // Response-ready generator: random, except when a hold is requested.
  initial begin
    rready = 0;
    bready = 0;
    forever begin
      @(posedge clk); #1;
      rready = !hold_r && ($urandom_range(3) != 0);
      bready = ($urandom_range(3) != 0);
    end
  end

  // Monitor: compare every presented response against the scoreboard head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst && (rvalid || bvalid)) begin
        check("ready_low_when_busy", {29'h0, arready, awready, wready}, 32'h0);
        if (q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_resp: rvalid=%b bvalid=%b with empty scoreboard", rvalid, bvalid);
        end else begin
          mon_e = q[0];
          check("resp_kind", {30'h0, rvalid, bvalid}, mon_e.is_rd ? 32'h2 : 32'h1);
          if (!prev_vld) check("latency", 32'(cyc - mon_e.hs), LAT);
          if (mon_e.is_rd) begin
            check("rdata", rdata, mon_e.data);
            check("rresp", {30'h0, rresp}, {30'h0, mon_e.resp});
            if (rready) begin void'(q.pop_front()); last_r_hs = cyc; end
          end else begin
            check("bresp", {30'h0, bresp}, {30'h0, mon_e.resp});
            if (bready) void'(q.pop_front());
          end
        end
      end
      prev_vld = rst && (rvalid || bvalid);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old_val;
    int          n;
    rst = 0; arvalid = 1; araddr = BASE;
    awvalid = 0; wvalid = 0; awaddr = 0; wdata = 0; wstrb = 0;

    // Reset held with a pending read request.
    repeat (3) begin
      @(negedge clk);
      check("rst_arready", arready, 0);
      check("rst_rvalid", rvalid, 0);
      check("rst_bvalid", bvalid, 0);
    end
    check("rst_rdata", rdata, 0);
    check("rst_rresp", {30'h0, rresp}, 0);
    @(posedge clk); #1;
    rst = 1; arvalid = 0;
    @(negedge clk);
    check("idle_arready", arready, 1);

    // Preload the words the random phase may read.
    for (int i = 0; i < 16; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF);
    for (int i = 1020; i < 1024; i++) do_write(BASE + 32'(4 * i), $urandom, 4'hF);

    // Full-word write/read and byte-strobe merge.
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    do_read(32'h8000_0010);
    do_write(32'h8000_0010, 32'h0000_AA00, 4'b0010);
    do_read(32'h8000_0010);
    wait_empty();
    check("strobe_merge_model", ref_mem[4], 32'hDEAD_AAEF);

    // Out-of-range accesses and the neighbouring last word.
    do_read(32'h7FFF_FFFC);
    do_write(BASE + 32'd4096, 32'h1234_5678, 4'hF);
    do_read(BASE + 32'd4092);

    // Response backpressure: rready held low for 5 cycles.
    wait_empty();
    hold_r = 1;
    do_read(BASE + 32'd8);
    n = 0;
    while (!rvalid && n < 50) begin @(negedge clk); n++; end
    if (!rvalid) timeout("hold_rvalid");
    repeat (5) begin
      @(negedge clk);
      check("hold_rvalid", rvalid, 1);
      check("hold_rdata", rdata, ref_mem[2]);
      check("hold_arready", arready, 0);
    end
    hold_r = 0;

    // Simultaneous read and write: read wins, write follows the R handshake.
    wait_empty();
    @(posedge clk); #1;
    arvalid = 1; araddr = BASE + 32'd12;
    awvalid = 1; wvalid = 1; awaddr = BASE + 32'd12; wdata = 32'hCAFE_F00D; wstrb = 4'hF;
    @(negedge clk);
    n = 0;
    while (!arready && n < 100) begin @(negedge clk); n++; end
    check("prio_awready", awready, 0);
    check("prio_wready", wready, 0);
    push_read(BASE + 32'd12);
    @(posedge clk); #1;
    arvalid = 0;
    @(negedge clk);
    n = 0;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (!awready) timeout("prio_write");
    else begin
      check("turnaround", 32'(cyc), 32'(last_r_hs + 1));
      push_write(BASE + 32'd12, 32'hCAFE_F00D, 4'hF);
    end
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    do_read(BASE + 32'd12);

    // Reset while the write is waiting: no response, word unchanged.
    wait_empty();
    old_val = ref_mem[5];
    @(posedge clk); #1;
    awvalid = 1; wvalid = 1; awaddr = BASE + 32'd20; wdata = ~old_val; wstrb = 4'hF;
    @(negedge clk);
    n = 0;
    while (!awready && n < 100) begin @(negedge clk); n++; end
    if (!awready) timeout("abort_aw");
    @(posedge clk); #1;
    rst = 0; awvalid = 0; wvalid = 0;
    repeat (3) begin
      @(negedge clk);
      check("abort_bvalid", bvalid, 0);
    end
    @(posedge clk); #1;
    rst = 1;
    do_read(BASE + 32'd20);

    // Random mix of reads and writes.
    repeat (200) begin
      if ($urandom_range(1) == 0) do_read(pick_addr());
      else do_write(pick_addr(), $urandom, 4'($urandom_range(15)));
    end
    wait_empty();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
